prog_loader: RTL



---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_if.sv | 13 +
 rtl/prog_loader_addr_gen.sv | 51 +++++
 rtl/prog_loader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths and FSM state encoding for the program loader.
package prog_loader_pkg;

    localparam int LOADER_ADDR_W = 20;
    localparam int LOADER_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        START = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - instruction word stream into the loader (valid/ready/last).
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic                     s_valid;
    logic [LOADER_DATA_W-1:0] s_data;
    logic                     s_last;
    logic                     s_ready;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);

endinterface

// File: rtl/prog_loader_addr_gen.sv
// rtl/prog_loader_addr_gen.sv - SRAM write pointer and word counter for the loader.
module prog_loader_addr_gen
    import prog_loader_pkg::*;
#(
    parameter logic [LOADER_ADDR_W-1:0] BASE_ADDR = 20'h00000,
    parameter int unsigned              ADDR_STEP = 4,
    parameter int unsigned              MAX_WORDS = 1024,
    parameter int unsigned              COUNT_W   = 11
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     step_i,
    output logic [LOADER_ADDR_W-1:0] ptr_o,
    output logic [COUNT_W-1:0]       count_o,
    output logic                     full_o,
    output logic                     last_slot_o
);

    logic [LOADER_ADDR_W-1:0] ptr_q, ptr_d;
    logic [COUNT_W-1:0]       count_q, count_d;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clear_i) begin
            ptr_d   = BASE_ADDR;
            count_d = '0;
        end else if (step_i) begin
            ptr_d   = ptr_q + LOADER_ADDR_W'(ADDR_STEP);
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= BASE_ADDR;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign ptr_o       = ptr_q;
    assign count_o     = count_q;
    assign full_o      = (count_q == COUNT_W'(MAX_WORDS));
    // A handshake while in the last slot fills the memory.
    assign last_slot_o = (count_q == COUNT_W'(MAX_WORDS - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams instruction words into SRAM, then releases the core; LOADER_CHECKSUM_EN adds sum check.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [LOADER_ADDR_W-1:0] BASE_ADDR = 20'h00000,
    parameter int unsigned              ADDR_STEP = 4,
    parameter int unsigned              MAX_WORDS = 1024
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     start_load,
    prog_loader_if.slave             src,
    output logic                     LOAD_CTRL,
    output logic [LOADER_ADDR_W-1:0] LOAD_ADDR,
    output logic [LOADER_DATA_W-1:0] LOAD_DATA,
    output logic                     CPU_START,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [10:0]              word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]              checksum,
    input  logic [31:0]              expected_sum
`endif
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_FLUSH = FLUSH;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DONE  = DONE;
    localparam logic [2:0] S_ERR   = ERR;

    logic [2:0]               state_q, state_d;
    logic                     load_ctrl_q;
    logic [LOADER_ADDR_W-1:0] load_addr_q;
    logic [LOADER_DATA_W-1:0] load_data_q;
    logic                     cpu_start_q;
    logic                     done_q, error_q;
    logic                     full_exit_q, full_exit_d;

    logic                     hs, begin_session, overflow, sum_bad;
    logic                     full, last_slot;
    logic [LOADER_ADDR_W-1:0] ptr;

    assign src.s_ready   = (state_q == S_LOAD);
    assign hs            = (state_q == S_LOAD) && src.s_valid;
    // start_load is only honoured between sessions; in LOAD it is ignored.
    assign begin_session = start_load &&
                           (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    prog_loader_addr_gen #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_STEP (ADDR_STEP),
        .MAX_WORDS (MAX_WORDS),
        .COUNT_W   (11)
    ) u_addr_gen (
        .clk_i       (CLK),
        .rst_ni      (RSTn),
        .clear_i     (begin_session),
        .step_i      (hs),
        .ptr_o       (ptr),
        .count_o     (word_count),
        .full_o      (full),
        .last_slot_o (last_slot)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (begin_session) sum_d = '0;
        else if (hs)       sum_d = sum_q + src.s_data;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign checksum = sum_q;
    assign sum_bad  = (sum_q != expected_sum);
`else
    assign sum_bad  = 1'b0;
`endif

    // Overflow: memory filled without s_last and the source still offers data.
    assign overflow = full && full_exit_q && src.s_valid;

    always_comb begin
        full_exit_d = full_exit_q;
        if (begin_session)                       full_exit_d = 1'b0;
        else if (hs && !src.s_last && last_slot) full_exit_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_load) state_d = S_LOAD;
            S_LOAD:  if (hs && (src.s_last || last_slot)) state_d = S_FLUSH;
            S_FLUSH: state_d = (overflow || sum_bad) ? S_ERR : S_START;
            S_START: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            load_ctrl_q <= 1'b0;
            load_addr_q <= BASE_ADDR;
            load_data_q <= '0;
            cpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            full_exit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_exit_q <= full_exit_d;
            load_ctrl_q <= hs;
            if (hs) begin
                load_addr_q <= ptr;
                load_data_q <= src.s_data;
            end
            cpu_start_q <= (state_d == S_START);
            if (begin_session) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end else begin
                if (state_d == S_DONE) done_q  <= 1'b1;
                if (state_d == S_ERR)  error_q <= 1'b1;
            end
        end
    end

    assign LOAD_CTRL = load_ctrl_q;
    assign LOAD_ADDR = load_addr_q;
    assign LOAD_DATA = load_data_q;
    assign CPU_START = cpu_start_q;
    assign done      = done_q;
    assign error     = error_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_START);

endmodule
